// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: header pattern, MSB-first length field, then N
// LSB-first payload bits, one bit per clkEn strobe.
module serial_frame_tx #(
  parameter int                HDR_W  = 4,
  parameter logic [HDR_W-1:0]  HDR    = 4'b1101,
  parameter int                CNT_W  = 4,
  parameter int                DATA_W = 2**CNT_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [DATA_W-1:0] data,
  output logic              txBit,
  output logic              txValid,
  output logic              busy,
  output logic              done
);

  localparam int               FW       = HDR_W + CNT_W + DATA_W;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_LEN, S_PAY} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_len;
  logic [FW-1:0]    r_frame;
  logic             r_txBit;
  logic             r_txValid;
  logic             r_busy;
  logic             r_done;
  logic             w_last;

  // Payload is reversed on load so the whole frame leaves MSB first from one shifter.
  function automatic logic [DATA_W-1:0] rev_bits(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

  // Flags the strobe that completes the final bit of the frame.
  always_comb begin
    w_last = 1'b0;
    if (r_state == S_LEN) begin
      w_last = (r_idx == CNT_LAST) && (r_len == '0);
    end else if (r_state == S_PAY) begin
      w_last = (r_idx == (r_len - ONE));
    end else begin
      w_last = 1'b0;
    end
  end

  // Frame FSM with registered line outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_frame   <= '0;
      r_txBit   <= 1'b0;
      r_txValid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len     <= len;
            r_frame   <= {HDR, len, rev_bits(data)};
            r_idx     <= '0;
            r_state   <= S_HDR;
            r_busy    <= 1'b1;
            r_txValid <= 1'b1;
            r_txBit   <= HDR[HDR_W-1];
          end
        end
        S_HDR, S_LEN, S_PAY: begin
          if (clkEn && w_last) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_txValid <= 1'b0;
            r_txBit   <= 1'b0;
            r_done    <= 1'b1;
          end else if (clkEn) begin
            r_frame <= r_frame << 1;
            r_txBit <= r_frame[FW-2];
            case (r_state)
              S_HDR: begin
                if (r_idx == HDR_LAST) begin
                  r_idx   <= '0;
                  r_state <= S_LEN;
                end else begin
                  r_idx <= r_idx + ONE;
                end
              end
              S_LEN: begin
                if (r_idx == CNT_LAST) begin
                  r_idx   <= '0;
                  r_state <= S_PAY;
                end else begin
                  r_idx <= r_idx + ONE;
                end
              end
              default: r_idx <= r_idx + ONE;
            endcase
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign txBit   = r_txBit;
  assign txValid = r_txValid;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx; expected bits are queued when a frame is
// requested and popped as each strobe completes a bit on the line.
module tb_serial_frame_tx;

  localparam logic [3:0] HDR = 4'b1101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clkEn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  len = 4'd0;
  logic [14:0] data = 15'd0;
  logic        txBit, txValid, busy, done;

  int   vectors = 0;
  int   miscompares = 0;
  logic q[$];
  logic rx_q[$];

  serial_frame_tx dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .start(start), .len(len), .data(data),
    .txBit(txBit), .txValid(txValid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] l, input logic [14:0] d);
    for (int i = 3; i >= 0; i--) q.push_back(HDR[i]);
    for (int i = 3; i >= 0; i--) q.push_back(l[i]);
    for (int i = 0; i < int'(l); i++) q.push_back(d[i]);
  endtask

  // One clock: a strobe while a bit is valid completes that bit, so check it now.
  task automatic tick(input logic en, input logic st);
    clkEn = en;
    start = st;
    if (en && txValid) begin
      rx_q.push_back(txBit);
      if (q.size() == 0) chk("extra_bit", {31'd0, txValid}, 32'd0);
      else chk("bit", {31'd0, txBit}, {31'd0, q.pop_front()});
    end
    @(posedge clk);
    #1;
    clkEn = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] l, input logic [14:0] d, input int period,
                           input logic accept_en, input int collide_at);
    int strobes;
    int cycles;
    bit fin;
    strobes = 0;
    cycles  = 0;
    fin     = 1'b0;
    len  = l;
    data = d;
    push_frame(l, d);
    rx_q.delete();
    tick(accept_en, 1'b1);
    chk("acc_busy", {31'd0, busy}, 32'd1);
    chk("acc_valid", {31'd0, txValid}, 32'd1);
    chk("acc_bit", {31'd0, txBit}, {31'd0, HDR[3]});
    chk("acc_done", {31'd0, done}, 32'd0);
    while (!fin && cycles < 400) begin
      for (int k = 1; k < period; k++) begin
        tick(1'b0, 1'b0);
        cycles++;
      end
      if (strobes == collide_at) begin
        len  = 4'd9;
        data = 15'($urandom);
        tick(1'b1, 1'b1);
      end else begin
        tick(1'b1, 1'b0);
      end
      cycles++;
      strobes++;
      if (done) fin = 1'b1;
    end
    chk("timeout", {31'd0, fin}, 32'd1);
    chk("strobes", strobes, 8 + int'(l));
    chk("cycles", cycles, (8 + int'(l)) * period);
    chk("q_empty", q.size(), 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_valid", {31'd0, txValid}, 32'd0);
    chk("end_bit", {31'd0, txBit}, 32'd0);
    chk("end_done", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [3:0]  rx_cnt;
    logic [4:0]  rx_pay;
    logic [3:0]  rx_hdr;

    // Reset dominates start and clkEn.
    rst = 1'b1; start = 1'b1; clkEn = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_bit", {31'd0, txBit}, 32'd0);
    chk("rst_valid", {31'd0, txValid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0; start = 1'b0; clkEn = 1'b0;
    tick(1'b0, 1'b0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);

    // Basic frame, strobe every 4 clocks.
    run_frame(4'd3, 15'b101, 4, 1'b0, -1);
    tick(1'b0, 1'b0);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Empty payload.
    run_frame(4'd0, 15'h7FFF, 2, 1'b0, -1);
    tick(1'b0, 1'b0);

    // Max frame with clkEn tied high.
    run_frame(4'd15, 15'h7FFF, 1, 1'b0, -1);
    tick(1'b0, 1'b0);

    // start mid-frame is ignored; len/data changes have no effect.
    run_frame(4'd4, 15'b1001, 2, 1'b0, 4);
    tick(1'b0, 1'b0);

    // start with clkEn in IDLE: that strobe does not count.
    run_frame(4'd2, 15'b10, 4, 1'b1, -1);

    // Back-to-back: accept in the done cycle.
    run_frame(4'd6, 15'b101101, 1, 1'b0, -1);
    run_frame(4'd1, 15'b0, 1, 1'b0, -1);
    tick(1'b0, 1'b0);

    // Abort on the 3rd payload bit.
    len = 4'd6; data = 15'b111111;
    push_frame(len, data);
    tick(1'b0, 1'b1);
    for (int s = 0; s < 10; s++) tick(1'b1, 1'b0);
    rst = 1'b1;
    tick(1'b1, 1'b0);
    rst = 1'b0;
    chk("abort_bit", {31'd0, txBit}, 32'd0);
    chk("abort_valid", {31'd0, txValid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    tick(1'b0, 1'b0);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    q.delete();
    run_frame(4'd5, 15'b10110, 3, 1'b0, -1);

    // Loopback: decode the captured line as the receiver would.
    tick(1'b0, 1'b0);
    run_frame(4'd5, 15'b01101, 2, 1'b0, -1);
    chk("rx_len", rx_q.size(), 32'd13);
    if (rx_q.size() == 13) begin
      for (int i = 0; i < 4; i++) rx_hdr[3-i] = rx_q[i];
      for (int i = 0; i < 4; i++) rx_cnt[3-i] = rx_q[4+i];
      for (int i = 0; i < 5; i++) rx_pay[i] = rx_q[8+i];
      chk("rx_hdr", {28'd0, rx_hdr}, 32'hD);
      chk("rx_count", {28'd0, rx_cnt}, 32'd5);
      chk("rx_payload", {27'd0, rx_pay}, 32'b01101);
    end
    tick(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
